vanilla_scoreboard_retire_monitor: RTL and testbench

//  Retire-side companion to the scoreboard tracker in testbenches/common. Watches the int/float scoreboard

---
 rtl/vanilla_scoreboard_tracker_pkg.sv | 22 ++
 rtl/vanilla_sb_retire_entry.sv | 34 +++
 rtl/vanilla_scoreboard_retire_monitor.sv | 109 ++++++++++
 tb/tb_vanilla_scoreboard_retire_monitor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vanilla_scoreboard_tracker_pkg.sv
// vanilla_scoreboard_tracker_pkg: scoreboard info types plus retire-monitor state and error types
package vanilla_scoreboard_tracker_pkg;
  localparam int RV32_reg_els_gp = 32;
  typedef struct packed {
    logic remote_dram_load;
    logic remote_global_load;
    logic remote_group_load;
    logic idiv;
  } vanilla_isb_info_s;
  typedef struct packed {
    logic remote_dram_load;
    logic remote_global_load;
    logic remote_group_load;
    logic fdiv_fsqrt;
  } vanilla_fsb_info_s;
  typedef enum logic [0:0] {SB_RETIRE_IDLE, SB_RETIRE_PENDING} sb_retire_state_e;
  typedef struct packed {
    logic spurious;
    logic multi;
    logic timeout;
  } sb_retire_err_s;
endpackage

// File: rtl/vanilla_sb_retire_entry.sv
// vanilla_sb_retire_entry: per-register pending FSM with saturating issue-to-retire latency counter
module vanilla_sb_retire_entry
  import vanilla_scoreboard_tracker_pkg::*;
#(
  parameter int lat_width_p = 16,
  parameter int timeout_p = 10000
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   pending_i,
  input  logic                   clear_i,
  output logic                   retire_o,
  output logic [lat_width_p-1:0] lat_o,
  output logic                   spurious_o,
  output logic                   timeout_o
);
  sb_retire_state_e state_r;
  logic [lat_width_p-1:0] lat_r;
  logic pend;
  assign pend = state_r == SB_RETIRE_PENDING;
  assign lat_o = &lat_r ? lat_r : lat_r + 1'b1;
  assign retire_o = pend && clear_i;
  assign spurious_o = !pend && clear_i;
  assign timeout_o = pend && lat_r == lat_width_p'(timeout_p);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= SB_RETIRE_IDLE;
      lat_r <= '0;
    end else begin
      state_r <= pend ? (clear_i ? SB_RETIRE_IDLE : SB_RETIRE_PENDING)
                      : (pending_i && !clear_i ? SB_RETIRE_PENDING : SB_RETIRE_IDLE);
      lat_r <= pend ? lat_o : '0;
    end
endmodule

// File: rtl/vanilla_scoreboard_retire_monitor.sv
// vanilla_scoreboard_retire_monitor: retire latency/count monitor with sticky protocol error flags.
// Define VANILLA_SB_RETIRE_MONITOR_DISPLAY_EN to print every retire and each error's first assertion.
module vanilla_scoreboard_retire_monitor
  import vanilla_scoreboard_tracker_pkg::*;
#(
  parameter int reg_els_p = RV32_reg_els_gp,
  parameter int reg_addr_width_lp = (reg_els_p > 1) ? $clog2(reg_els_p) : 1,
  parameter int lat_width_p = 16,
  parameter int cnt_width_p = 32,
  parameter int timeout_p = 10000
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  vanilla_isb_info_s            int_sb_i [reg_els_p],
  input  vanilla_fsb_info_s            float_sb_i [reg_els_p],
  input  logic                         int_sb_clear_i,
  input  logic [reg_addr_width_lp-1:0] int_sb_clear_id_i,
  input  logic                         float_sb_clear_i,
  input  logic [reg_addr_width_lp-1:0] float_sb_clear_id_i,
  output logic [cnt_width_p-1:0]       int_retired_o,
  output logic [cnt_width_p-1:0]       float_retired_o,
  output logic [cnt_width_p-1:0]       lat_sum_o,
  output logic [lat_width_p-1:0]       int_lat_max_o,
  output logic [lat_width_p-1:0]       float_lat_max_o,
  output sb_retire_err_s               err_o,
  output logic [reg_addr_width_lp-1:0] err_reg_o,
  output logic                         err_float_o
);
  logic [1:0][reg_els_p-1:0] pend, clr, ret, spur_raw, spur, mul, tmo, e;
  logic [lat_width_p-1:0] lat [2][reg_els_p];
  logic int_ret, float_ret, first_float;
  logic [lat_width_p-1:0] int_lat, float_lat;
  logic [reg_addr_width_lp-1:0] first_reg;
  sb_retire_err_s new_err;
  for (genvar r = 0; r < reg_els_p; r++) begin : g_reg
    assign pend[0][r] = |int_sb_i[r];
    assign pend[1][r] = |float_sb_i[r];
    assign mul[0][r] = $countones(int_sb_i[r]) > 1;
    assign mul[1][r] = $countones(float_sb_i[r]) > 1;
    assign clr[0][r] = int_sb_clear_i && int_sb_clear_id_i == reg_addr_width_lp'(r);
    assign clr[1][r] = float_sb_clear_i && float_sb_clear_id_i == reg_addr_width_lp'(r);
  end
  for (genvar f = 0; f < 2; f++) begin : g_file
    for (genvar r = 0; r < reg_els_p; r++) begin : g_reg
      vanilla_sb_retire_entry #(.lat_width_p(lat_width_p), .timeout_p(timeout_p)) entry (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .pending_i(pend[f][r]),
        .clear_i(clr[f][r]),
        .retire_o(ret[f][r]),
        .lat_o(lat[f][r]),
        .spurious_o(spur_raw[f][r]),
        .timeout_o(tmo[f][r])
      );
      // x0 writes are discarded by the core, so clearing it while idle is legal
      assign spur[f][r] = spur_raw[f][r] && (f != 0 || r != 0);
    end
  end
  assign e = spur | mul | tmo;
  assign new_err = '{spurious: |spur, multi: |mul, timeout: |tmo};
  assign int_ret = |ret[0];
  assign float_ret = |ret[1];
  assign int_lat = int_ret ? lat[0][int_sb_clear_id_i] : '0;
  assign float_lat = float_ret ? lat[1][float_sb_clear_id_i] : '0;
  // descending scan so the last hit is the int file, lowest register
  always_comb begin
    first_reg = '0;
    first_float = 1'b0;
    for (int f = 1; f >= 0; f--)
      for (int r = reg_els_p - 1; r >= 0; r--)
        if (e[f][r]) begin
          first_reg = reg_addr_width_lp'(r);
          first_float = f[0];
        end
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      int_retired_o <= '0;
      float_retired_o <= '0;
      lat_sum_o <= '0;
      int_lat_max_o <= '0;
      float_lat_max_o <= '0;
      err_o <= '0;
      err_reg_o <= '0;
      err_float_o <= 1'b0;
    end else begin
      int_retired_o <= int_retired_o + cnt_width_p'(int_ret);
      float_retired_o <= float_retired_o + cnt_width_p'(float_ret);
      lat_sum_o <= lat_sum_o + cnt_width_p'(int_lat) + cnt_width_p'(float_lat);
      int_lat_max_o <= int_lat > int_lat_max_o ? int_lat : int_lat_max_o;
      float_lat_max_o <= float_lat > float_lat_max_o ? float_lat : float_lat_max_o;
      err_o <= err_o | new_err;
      if (err_o == '0 && |e) begin
        err_reg_o <= first_reg;
        err_float_o <= first_float;
      end
    end
`ifdef VANILLA_SB_RETIRE_MONITOR_DISPLAY_EN
  always @(posedge clk_i)
    if (reset_n_i) begin
      if (int_ret) $display("[%m] retire int x%0d lat=%0d t=%0t", int_sb_clear_id_i, int_lat, $time);
      if (float_ret) $display("[%m] retire float f%0d lat=%0d t=%0t", float_sb_clear_id_i, float_lat, $time);
      if (new_err.spurious && !err_o.spurious) $display("[%m] error spurious clear t=%0t", $time);
      if (new_err.multi && !err_o.multi) $display("[%m] error multi-class pending t=%0t", $time);
      if (new_err.timeout && !err_o.timeout) $display("[%m] error pending timeout t=%0t", $time);
    end
`else
`endif
endmodule

// File: tb/tb_vanilla_scoreboard_retire_monitor.sv
// tb_vanilla_scoreboard_retire_monitor: directed checks of retire counting, latency and error flags
module tb_vanilla_scoreboard_retire_monitor;
  import vanilla_scoreboard_tracker_pkg::*;
  localparam int regs = 32;
  localparam int aw = 5;
  localparam int lw = 16;
  localparam int cw = 32;
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  vanilla_isb_info_s int_sb [regs];
  vanilla_fsb_info_s float_sb [regs];
  logic int_clr, float_clr;
  logic [aw-1:0] int_id, float_id, err_reg;
  logic [cw-1:0] int_ret, float_ret, lat_sum;
  logic [lw-1:0] int_max, float_max;
  sb_retire_err_s err;
  logic err_float;
  int checks = 0;
  int passed = 0;
  always #5 clk_i = ~clk_i;
  vanilla_scoreboard_retire_monitor #(
    .reg_els_p(regs), .lat_width_p(lw), .cnt_width_p(cw), .timeout_p(20)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .int_sb_i(int_sb),
    .float_sb_i(float_sb),
    .int_sb_clear_i(int_clr),
    .int_sb_clear_id_i(int_id),
    .float_sb_clear_i(float_clr),
    .float_sb_clear_id_i(float_id),
    .int_retired_o(int_ret),
    .float_retired_o(float_ret),
    .lat_sum_o(lat_sum),
    .int_lat_max_o(int_max),
    .float_lat_max_o(float_max),
    .err_o(err),
    .err_reg_o(err_reg),
    .err_float_o(err_float)
  );
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic clear_inputs();
    foreach (int_sb[i]) int_sb[i] = '0;
    foreach (float_sb[i]) float_sb[i] = '0;
    int_clr = 1'b0;
    float_clr = 1'b0;
    int_id = '0;
    float_id = '0;
  endtask
  task automatic do_reset();
    reset_n_i = 1'b0;
    clear_inputs();
    tick();
    reset_n_i = 1'b1;
    tick();
  endtask
  initial begin
    clear_inputs();
    tick(2);
    chk("rst_int_ret", int_ret, 0);
    chk("rst_float_ret", float_ret, 0);
    chk("rst_lat_sum", lat_sum, 0);
    chk("rst_int_max", int_max, 0);
    chk("rst_float_max", float_max, 0);
    chk("rst_err", err, 0);
    chk("rst_err_reg", {err_float, err_reg}, 0);
    reset_n_i = 1'b1;
    tick();
    // int r5: five edges after the pending bit, then clear -> latency 5
    int_sb[5].remote_dram_load = 1'b1;
    tick(5);
    int_clr = 1'b1;
    int_id = 5'd5;
    chk("t1_pre_cnt", int_ret, 0);
    tick();
    int_clr = 1'b0;
    int_sb[5] = '0;
    chk("t1_int_ret", int_ret, 1);
    chk("t1_lat_sum", lat_sum, 5);
    chk("t1_int_max", int_max, 5);
    chk("t1_err", err, 0);
    int_sb[6].idiv = 1'b1;
    tick(2);
    int_clr = 1'b1;
    int_id = 5'd6;
    tick();
    int_clr = 1'b0;
    int_sb[6] = '0;
    chk("t1b_int_ret", int_ret, 2);
    chk("t1b_lat_sum", lat_sum, 7);
    chk("t1b_int_max_kept", int_max, 5);
    chk("t1b_float_ret", float_ret, 0);
    // spurious: x0 exempt, then f3 idle clear, then later errors leave first record alone
    do_reset();
    int_clr = 1'b1;
    int_id = 5'd0;
    tick();
    int_clr = 1'b0;
    chk("t2_x0_exempt", err, 0);
    float_clr = 1'b1;
    float_id = 5'd3;
    tick();
    float_clr = 1'b0;
    chk("t2_spur_err", err, 3'b100);
    chk("t2_spur_reg", err_reg, 3);
    chk("t2_spur_float", err_float, 1);
    int_clr = 1'b1;
    int_id = 5'd4;
    tick();
    int_clr = 1'b0;
    chk("t2_first_reg_kept", err_reg, 3);
    chk("t2_first_float_kept", err_float, 1);
    // multi-class pending
    do_reset();
    int_sb[7].remote_dram_load = 1'b1;
    int_sb[7].idiv = 1'b1;
    tick();
    chk("t3_multi_err", err, 3'b010);
    chk("t3_multi_reg", {err_float, err_reg}, 7);
    do_reset();
    float_sb[1].remote_dram_load = 1'b1;
    float_sb[1].fdiv_fsqrt = 1'b1;
    int_sb[12].remote_group_load = 1'b1;
    int_sb[12].idiv = 1'b1;
    tick();
    chk("t3_tie_int_wins", {err_float, err_reg}, 12);
    // timeout at lat 20, retire at lat 30 -> latency 31
    do_reset();
    int_sb[9].remote_group_load = 1'b1;
    tick(21);
    chk("t4_no_timeout_yet", err, 0);
    tick();
    chk("t4_timeout", err, 3'b001);
    chk("t4_timeout_reg", {err_float, err_reg}, 9);
    tick(9);
    int_clr = 1'b1;
    int_id = 5'd9;
    tick();
    int_clr = 1'b0;
    int_sb[9] = '0;
    chk("t4_int_ret", int_ret, 1);
    chk("t4_lat_sum", lat_sum, 31);
    chk("t4_int_max", int_max, 31);
    chk("t4_err_kept", err, 3'b001);
    // same-cycle int/float retire with int re-set
    do_reset();
    float_sb[2].fdiv_fsqrt = 1'b1;
    tick(3);
    int_sb[2].idiv = 1'b1;
    tick(3);
    int_clr = 1'b1;
    int_id = 5'd2;
    float_clr = 1'b1;
    float_id = 5'd2;
    tick();
    int_clr = 1'b0;
    float_clr = 1'b0;
    float_sb[2] = '0;
    chk("t5_int_ret", int_ret, 1);
    chk("t5_float_ret", float_ret, 1);
    chk("t5_lat_sum", lat_sum, 9);
    chk("t5_int_max", int_max, 3);
    chk("t5_float_max", float_max, 6);
    tick();
    int_clr = 1'b1;
    tick();
    int_clr = 1'b0;
    int_sb[2] = '0;
    chk("t5_repend_ret", int_ret, 2);
    chk("t5_repend_sum", lat_sum, 10);
    chk("t5_repend_err", err, 0);
    // async reset mid-PENDING
    do_reset();
    int_sb[6].idiv = 1'b1;
    tick(2);
    int_clr = 1'b1;
    int_id = 5'd6;
    tick();
    int_clr = 1'b0;
    int_sb[6] = '0;
    chk("t6_pre_ret", int_ret, 1);
    int_sb[5].remote_global_load = 1'b1;
    tick(4);
    #3;
    reset_n_i = 1'b0;
    int_sb[5] = '0;
    #1;
    chk("t6_async_ret", int_ret, 0);
    chk("t6_async_sum", lat_sum, 0);
    chk("t6_async_max", int_max, 0);
    reset_n_i = 1'b1;
    tick();
    int_clr = 1'b1;
    int_id = 5'd5;
    tick();
    int_clr = 1'b0;
    chk("t6_spur_err", err, 3'b100);
    chk("t6_spur_reg", {err_float, err_reg}, 5);
    chk("t6_no_retire", int_ret, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
